// File: rtl/scan_chain_ctrl.sv
// scan_chain_ctrl: drives a chain of scan_dff cells through one structural test.
//   A stimulus pattern is shifted in MSB first, one functional capture edge is
//   issued, and the captured response is shifted out of the chain tail. The
//   response is then compared against an expected vector.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   start      begin one test (sampled only while idle)
//   pattern_in stimulus; bit k ends up in chain cell k (cell 0 = head)
//   expected   expected capture response, same indexing
//   scan_out   q of the chain tail cell
//   mode       to all cells: 1 = shift, 0 = functional/capture
//   scan_in    to the head cell scan_in
//   busy       high while the chain is being loaded, captured and unloaded
//   done       one-cycle pulse when a test completes
//   pass       captured == expected, valid from done until the next start
//   captured   response unloaded from the chain, held until the next start
module scan_chain_ctrl #(
  parameter int unsigned CHAIN_LEN = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CHAIN_LEN-1:0] pattern_in,
  input  logic [CHAIN_LEN-1:0] expected,
  input  logic                 scan_out,
  output logic                 mode,
  output logic                 scan_in,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CHAIN_LEN-1:0] captured
);

  localparam int unsigned CntW = $clog2(CHAIN_LEN + 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StCapture,
    StUnload,
    StDone
  } state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  // Only the bits still to be shifted after the first one are kept; the MSB
  // is presented on scan_in directly from pattern_in at the start edge.
  logic [CHAIN_LEN-2:0] pat_q, pat_d;
  logic [CHAIN_LEN-1:0] exp_q, exp_d;
  logic                 mode_q, mode_d;
  logic                 scan_in_q, scan_in_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic [CHAIN_LEN-1:0] cap_q, cap_d;

  logic [CHAIN_LEN-1:0] cap_shift;
  logic                 last_bit;

  assign cap_shift = {cap_q[CHAIN_LEN-2:0], scan_out};
  assign last_bit  = (cnt_q == CntW'(CHAIN_LEN - 1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pat_d     = pat_q;
    exp_d     = exp_q;
    mode_d    = mode_q;
    scan_in_d = scan_in_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pass_d    = pass_q;
    cap_d     = cap_q;

    case (state_q)
      StIdle: begin
        mode_d    = 1'b0;
        scan_in_d = 1'b0;
        if (start) begin
          state_d   = StLoad;
          pat_d     = pattern_in[CHAIN_LEN-2:0];
          exp_d     = expected;
          mode_d    = 1'b1;
          scan_in_d = pattern_in[CHAIN_LEN-1];
          cnt_d     = '0;
          busy_d    = 1'b1;
          cap_d     = '0;
          pass_d    = 1'b0;
        end
      end

      StLoad: begin
        if (last_bit) begin
          state_d   = StCapture;
          mode_d    = 1'b0;
          scan_in_d = 1'b0;
          cnt_d     = '0;
        end else begin
          cnt_d     = cnt_q + CntW'(1);
          scan_in_d = pat_q[CHAIN_LEN-2];
          pat_d     = pat_q << 1;
        end
      end

      StCapture: begin
        // Single functional edge happens while mode is low; re-enter shift.
        state_d = StUnload;
        mode_d  = 1'b1;
        cnt_d   = '0;
      end

      StUnload: begin
        scan_in_d = 1'b0;
        cap_d     = cap_shift;
        if (last_bit) begin
          state_d = StDone;
          mode_d  = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (cap_shift == exp_q);
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      pat_q     <= '0;
      exp_q     <= '0;
      mode_q    <= 1'b0;
      scan_in_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      cap_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pat_q     <= pat_d;
      exp_q     <= exp_d;
      mode_q    <= mode_d;
      scan_in_q <= scan_in_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      cap_q     <= cap_d;
    end
  end

  assign mode     = mode_q;
  assign scan_in  = scan_in_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign captured = cap_q;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl: an 8-cell scan chain model whose functional d is
// either the inverted cell contents or a constant vector, a scoreboard of
// expected test results, and a monitor that checks each done pulse.
module tb_scan_chain_ctrl;

  localparam int unsigned N = 8;
  localparam int unsigned DoneLat = 2 * N + 1;
  localparam int unsigned TestLen = DoneLat + 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] pattern_in = '0;
  logic [N-1:0] expected = '0;
  logic         scan_out;
  logic         mode;
  logic         scan_in;
  logic         busy;
  logic         done;
  logic         pass;
  logic [N-1:0] captured;

  scan_chain_ctrl #(.CHAIN_LEN(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pattern_in (pattern_in),
    .expected   (expected),
    .scan_out   (scan_out),
    .mode       (mode),
    .scan_in    (scan_in),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .captured   (captured)
  );

  always #5 clk = ~clk;

  // Chain of scan_dff cells; cell 0 is the head.
  logic [N-1:0] chain = '0;
  logic         d_inv = 1'b1;
  logic [N-1:0] d_const = '0;

  always @(posedge clk) begin
    if (mode) chain <= {chain[N-2:0], scan_in};
    else      chain <= d_inv ? ~chain : d_const;
  end
  assign scan_out = chain[N-1];

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [N-1:0] cap;
    logic         pass;
    int unsigned  s;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned next_ok = 0;
  int unsigned s_last = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Functional response of the chain: inverter feedback or a constant.
  function automatic logic [N-1:0] model_cap(input logic inv, input logic [N-1:0] cval,
                                             input logic [N-1:0] pat);
    return inv ? ~pat : cval;
  endfunction

  task automatic push_exp(input logic [N-1:0] pat, input logic [N-1:0] ex, input int unsigned s);
    exp_t e;
    e.cap  = model_cap(d_inv, d_const, pat);
    e.pass = (e.cap == ex);
    e.s    = s;
    q.push_back(e);
  endtask

  task automatic wait_idle();
    @(negedge clk);
    while (cyc + 1 < next_ok) @(negedge clk);
  endtask

  task automatic wait_k(input int unsigned k);
    while (cyc < s_last + k) @(negedge clk);
  endtask

  // Starts one test; returns at the negedge just after the start-sampling edge.
  task automatic issue(input logic inv, input logic [N-1:0] cval, input logic [N-1:0] pat,
                       input logic [N-1:0] ex, input bit push);
    wait_idle();
    d_inv      = inv;
    d_const    = cval;
    start      = 1'b1;
    pattern_in = pat;
    expected   = ex;
    s_last     = cyc + 1;
    if (push) push_exp(pat, ex, s_last);
    next_ok = s_last + TestLen;
    @(negedge clk);
    start      = 1'b0;
    pattern_in = N'($urandom);
    expected   = N'($urandom);
  endtask

  always @(negedge clk) begin
    if (rst && done) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected done: got done=1 required no pending test (cycle %0d)", cyc);
      end else begin
        mon_e = q.pop_front();
        check("captured", 32'(captured), 32'(mon_e.cap));
        check("pass", 32'(pass), 32'(mon_e.pass));
        check("done latency", cyc - mon_e.s, DoneLat);
      end
    end
  end

  logic [19:0] busy_v, mode_v, busy_x, mode_x;

  initial begin
    // Reset values.
    repeat (3) @(negedge clk);
    check("reset mode", 32'(mode), 0);
    check("reset scan_in", 32'(scan_in), 0);
    check("reset busy", 32'(busy), 0);
    check("reset done", 32'(done), 0);
    check("reset pass", 32'(pass), 0);
    check("reset captured", 32'(captured), 0);
    rst = 1'b1;

    // Reset during LOAD abandons the test without a done pulse.
    issue(1'b1, 8'h00, 8'hA5, 8'h5A, 1'b0);
    wait_k(4);
    rst = 1'b0;
    #1;
    check("midload mode", 32'(mode), 0);
    check("midload scan_in", 32'(scan_in), 0);
    check("midload busy", 32'(busy), 0);
    check("midload captured", 32'(captured), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    next_ok = cyc + 1;
    repeat (25) @(negedge clk);

    // Inverter chain, matching expectation.
    issue(1'b1, 8'h00, 8'hA5, 8'h5A, 1'b1);
    wait_k(8);
    check("chain before capture A5", 32'(chain), 32'h A5);

    // Inverter chain, mismatching expectation; waveform profile.
    issue(1'b1, 8'h00, 8'hA5, 8'h5B, 1'b1);
    check("cleared captured", 32'(captured), 0);
    check("cleared pass", 32'(pass), 0);
    for (int k = 0; k < 20; k++) begin
      busy_v[k] = busy;
      mode_v[k] = mode;
      busy_x[k] = (k < 17);
      mode_x[k] = (k < 8) || (k >= 9 && k < 17);
      @(negedge clk);
    end
    check("busy profile", 32'(busy_v), 32'(busy_x));
    check("mode profile", 32'(mode_v), 32'(mode_x));

    // Constant functional data; chain order check just before capture.
    issue(1'b0, 8'h3C, 8'hFF, 8'h3C, 1'b1);
    wait_k(8);
    check("chain before capture FF", 32'(chain), 32'h FF);

    // start during UNLOAD and during DONE is ignored.
    issue(1'b1, 8'h00, 8'hA5, 8'h5A, 1'b1);
    wait_k(12);
    start = 1'b1; pattern_in = 8'h00; expected = 8'h00;
    @(negedge clk);
    start = 1'b0;
    wait_k(17);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_k(19);
    check("no restart after ignored start", 32'(busy), 0);

    // start held high: back-to-back tests with one idle cycle between.
    wait_idle();
    d_inv = 1'b1;
    start = 1'b1; pattern_in = 8'h01; expected = 8'hFE;
    s_last = cyc + 1;
    push_exp(8'h01, 8'hFE, s_last);
    wait_k(5);
    pattern_in = 8'h80; expected = 8'h7F;
    push_exp(8'h80, 8'h7F, s_last + TestLen);
    wait_k(18);
    check("held start idle gap", 32'(busy), 0);
    wait_k(19);
    check("held start restart", 32'(busy), 1);
    start = 1'b0;
    next_ok = s_last + 2 * TestLen;

    // Randomized tests.
    for (int i = 0; i < 20; i++) begin
      logic         inv;
      logic [N-1:0] cv, pat, ex;
      inv = 1'($urandom_range(0, 1));
      cv  = N'($urandom);
      pat = N'($urandom);
      ex  = ($urandom_range(0, 1) == 1) ? model_cap(inv, cv, pat) : N'($urandom);
      issue(inv, cv, pat, ex, 1'b1);
      wait_k(8);
      check("chain before capture rand", 32'(chain), 32'(pat));
    end

    for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clk);
    check("scoreboard drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/scan_chain_ctrl.md
Name: scan_chain_ctrl

Overview:
Test controller that sits directly upstream and downstream of a chain of scan_dff cells. It drives the chain's shared mode and head scan_in. It shifts a parallel test pattern in, issues one functional capture clock, then shifts the captured response out from the chain tail. It compares the response against an expected vector and reports pass/fail with a done pulse.

Parameters:
CHAIN_LEN, 8, number of scan_dff cells in the chain (>=2); internal bit counter width = clog2(CHAIN_LEN+1)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous active-low reset
start  input  1  begin one test; sampled only in IDLE
pattern_in  input  CHAIN_LEN  stimulus; bit k lands in chain cell k (cell 0 = head)
expected  input  CHAIN_LEN  expected capture response, same indexing
scan_out  input  1  q of the chain tail cell (CHAIN_LEN-1)
mode  output  1  to all cells; 1 = shift, 0 = functional/capture
scan_in  output  1  to head cell scan_in
busy  output  1  high from LOAD through UNLOAD
done  output  1  one-cycle pulse at end of test
pass  output  1  captured == expected, valid from done, held until next start
captured  output  CHAIN_LEN  response unloaded from chain, held until next start

Behaviour:
- All outputs are registered.
- Reset (rst=0, async, any state): state=IDLE, mode=0, scan_in=0, busy=0, done=0, pass=0, captured=0, counter=0, pattern latch=0. Reset mid-test abandons the test; no done pulse is issued.
- States: IDLE, LOAD, CAPTURE, UNLOAD, DONE.
- IDLE: mode=0, scan_in=0. On an edge with start=1:
  - latch pattern_in and expected;
  - go to LOAD with mode=1, scan_in=pattern_in[CHAIN_LEN-1], counter=0.
- LOAD: CHAIN_LEN edges.
  - Each edge the chain shifts; scan_in advances to the next lower pattern bit (MSB first, bit 0 last).
  - After the CHAIN_LEN-th LOAD edge: go to CAPTURE with mode=0, scan_in=0.
  - Result: cell k holds pattern bit k.
- CAPTURE: exactly one edge with mode=0; the chain loads its d inputs. Then go to UNLOAD with mode=1, counter=0.
- UNLOAD: CHAIN_LEN edges, scan_in=0.
  - Each edge: captured <= {captured[CHAIN_LEN-2:0], scan_out}. The first sampled bit is tail cell CHAIN_LEN-1 and ends at captured[CHAIN_LEN-1]; the last is cell 0 and ends at captured[0].
  - After the CHAIN_LEN-th UNLOAD edge: go to DONE with mode=0 and busy=0. Also set done=1 and pass = (final captured == latched expected), computed on the shifted-in value.
- DONE: one cycle, then IDLE with done=0. pass and captured hold.
- Latency: done is high in the cycle following the (2*CHAIN_LEN+1)-th edge after the start-sampling edge (17 for CHAIN_LEN=8).
- start while busy or in DONE: ignored. pattern_in/expected changes after the start edge: no effect.
- start held high continuously: a new test begins from IDLE, one cycle after done drops (back-to-back tests, one idle cycle between).
- At start, captured is cleared to 0 and pass to 0.
- mode never glitches within a cycle; it changes only on clk edges, and scan_in is stable whenever mode=1 at an edge.

Test Plan:
- Reset mid-LOAD: assert rst=0 at edge 4 of LOAD -> mode=0, scan_in=0, busy=0, done never pulses, captured=0; a later start runs a full test correctly.
- CHAIN_LEN=8 bench chain of 8 scan_dff, cell d = ~q (inverter feedback), pattern_in=8'hA5, expected=8'h5A -> captured=8'h5A, pass=1, done pulse exactly 17 edges after start edge.
- Same chain, expected=8'h5B -> captured=8'h5A, pass=0; busy high for 17 cycles; mode=1 for 8 cycles, 0 for 1, 1 for 8.
- Cell d tied to constant 8'h3C, pattern_in=8'hFF -> captured=8'h3C regardless of pattern. Also check the chain holds 8'hFF just before the CAPTURE edge (bit order check).
- start pulsed again mid-UNLOAD with new pattern_in=8'h00 -> ignored; captured/pass reflect the first test; exactly one done pulse.
- start held high with pattern_in=8'h01, then 8'h80 between tests -> two consecutive tests, one IDLE cycle between done and next busy; each pass is correct.
